// File: rtl/pe_issue_arbiter_if.sv
// Request, PE-issue and response bundle shared by pe_issue_arbiter and its environment.
// grant_cnt and CNT_W exist only when PE_ARB_STATS_EN is defined.
interface pe_issue_arbiter_if #(
    parameter int unsigned N_REQ = 4
`ifdef PE_ARB_STATS_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [32*N_REQ-1:0] req_opcode;
    logic [32*N_REQ-1:0] req_op1;
    logic [32*N_REQ-1:0] req_op2;
    logic [32*N_REQ-1:0] req_op3;
    logic                hold;

    logic [31:0]         pe_opcode;
    logic [31:0]         pe_op1;
    logic [31:0]         pe_op2;
    logic [31:0]         pe_op3;
    logic                pe_valid;
    logic [31:0]         pe_result;
    logic                pe_result_valid;

    logic [N_REQ-1:0]    rsp_valid;
    logic [31:0]         rsp_data;
    logic                idle;
    logic                err_sync;
`ifdef PE_ARB_STATS_EN
    logic [CNT_W*N_REQ-1:0] grant_cnt;
`endif

    // Requesters plus PE side of the environment.
    modport master (
        output req_valid, req_opcode, req_op1, req_op2, req_op3, hold,
        output pe_result, pe_result_valid,
        input  req_ready, pe_opcode, pe_op1, pe_op2, pe_op3, pe_valid,
        input  rsp_valid, rsp_data, idle, err_sync
`ifdef PE_ARB_STATS_EN
        ,
        input  grant_cnt
`endif
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_opcode, req_op1, req_op2, req_op3, hold,
        input  pe_result, pe_result_valid,
        output req_ready, pe_opcode, pe_op1, pe_op2, pe_op3, pe_valid,
        output rsp_valid, rsp_data, idle, err_sync
`ifdef PE_ARB_STATS_EN
        ,
        output grant_cnt
`endif
    );
endinterface

// File: rtl/pe_issue_arbiter.sv
// Round-robin issue arbiter sharing one PE core among N_REQ requesters, with tag-based routing
// of results. Define PE_ARB_STATS_EN to add saturating per-requester grant counters.
module pe_issue_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned PE_LAT = 2
`ifdef PE_ARB_STATS_EN
    ,
    parameter int unsigned CNT_W  = 16
`endif
) (
    input logic               clk,
    input logic               rst_n,
    pe_issue_arbiter_if.slave bus
);
    localparam int unsigned ID_W = $clog2(N_REQ);

    logic [ID_W-1:0]  rr_ptr_q;
    logic [ID_W-1:0]  rr_ptr_d;
    logic [ID_W-1:0]  win_id;
    logic [ID_W-1:0]  cand;
    logic             found;
    logic             handshake;
    logic [N_REQ-1:0] grant;

    logic [31:0]      sel_opcode;
    logic [31:0]      sel_op1;
    logic [31:0]      sel_op2;
    logic [31:0]      sel_op3;

    logic             pe_valid_q;
    logic [31:0]      pe_opcode_q;
    logic [31:0]      pe_op1_q;
    logic [31:0]      pe_op2_q;
    logic [31:0]      pe_op3_q;
    logic [ID_W-1:0]  pe_id_q;

    logic [PE_LAT-1:0] tag_vld_q;
    logic [ID_W-1:0]   tag_id_q [PE_LAT];
    logic              out_vld;
    logic [ID_W-1:0]   out_id;
    logic [N_REQ-1:0]  out_onehot;

    logic [N_REQ-1:0] rsp_valid_q;
    logic [31:0]      rsp_data_q;
    logic             err_sync_q;

    // First pending requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        cand   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr_q) + k) % N_REQ);
            if (!found && bus.req_valid[cand]) begin
                found  = 1'b1;
                win_id = cand;
            end
        end
    end

    // Reset gates the grant so req_ready reads zero while rst_n is low.
    assign handshake = found & ~bus.hold & rst_n;

    always_comb begin
        grant = '0;
        if (handshake) begin
            grant[win_id] = 1'b1;
        end
    end

    assign rr_ptr_d = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + ID_W'(1);

    always_comb begin
        sel_opcode = bus.req_opcode[31:0];
        sel_op1    = bus.req_op1[31:0];
        sel_op2    = bus.req_op2[31:0];
        sel_op3    = bus.req_op3[31:0];
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                sel_opcode = bus.req_opcode[32*i +: 32];
                sel_op1    = bus.req_op1[32*i +: 32];
                sel_op2    = bus.req_op2[32*i +: 32];
                sel_op3    = bus.req_op3[32*i +: 32];
            end
        end
    end

    assign out_vld = tag_vld_q[PE_LAT-1];
    assign out_id  = tag_id_q[PE_LAT-1];

    always_comb begin
        out_onehot = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            out_onehot[i] = (out_id == ID_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            pe_valid_q  <= 1'b0;
            pe_opcode_q <= '0;
            pe_op1_q    <= '0;
            pe_op2_q    <= '0;
            pe_op3_q    <= '0;
            pe_id_q     <= '0;
            tag_vld_q   <= '0;
            for (int unsigned s = 0; s < PE_LAT; s++) begin
                tag_id_q[s] <= '0;
            end
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_sync_q  <= 1'b0;
        end else begin
            pe_valid_q <= handshake;
            if (handshake) begin
                pe_opcode_q <= sel_opcode;
                pe_op1_q    <= sel_op1;
                pe_op2_q    <= sel_op2;
                pe_op3_q    <= sel_op3;
                pe_id_q     <= win_id;
                rr_ptr_q    <= rr_ptr_d;
            end

            // Stage 0 loads alongside the PE issue, so stage PE_LAT-1 lines up with the result.
            tag_vld_q[0] <= pe_valid_q;
            tag_id_q[0]  <= pe_id_q;
            for (int unsigned s = 1; s < PE_LAT; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_id_q[s]  <= tag_id_q[s-1];
            end

            rsp_valid_q <= '0;
            if (out_vld && bus.pe_result_valid) begin
                rsp_valid_q <= out_onehot;
                rsp_data_q  <= bus.pe_result;
            end
            if (out_vld != bus.pe_result_valid) begin
                err_sync_q <= 1'b1;
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.pe_valid  = pe_valid_q;
    assign bus.pe_opcode = pe_opcode_q;
    assign bus.pe_op1    = pe_op1_q;
    assign bus.pe_op2    = pe_op2_q;
    assign bus.pe_op3    = pe_op3_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.err_sync  = err_sync_q;
    assign bus.idle      = ~handshake & ~pe_valid_q & ~(|tag_vld_q);

`ifdef PE_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [N_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (grant[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
        assign bus.grant_cnt[CNT_W*g +: CNT_W] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_pe_issue_arbiter.sv
// Self-checking bench for pe_issue_arbiter: directed scenarios plus randomized traffic
// checked against a rotating-priority scoreboard model.
module tb_pe_issue_arbiter;
    localparam int unsigned N_REQ  = 4;
    localparam int unsigned PE_LAT = 2;
`ifdef PE_ARB_STATS_EN
    localparam int unsigned CNT_W  = 3;
`endif
    localparam logic [31:0] OP_ADD = 32'h0210_0000;
    localparam logic [31:0] OP_SUB = 32'h0220_0000;
    localparam logic [31:0] OP_MUL = 32'h0230_0000;
    localparam logic [31:0] OP_XOR = 32'h0240_0000;

    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

`ifdef PE_ARB_STATS_EN
    pe_issue_arbiter_if #(.N_REQ(N_REQ), .CNT_W(CNT_W)) bus ();
    pe_issue_arbiter #(.N_REQ(N_REQ), .PE_LAT(PE_LAT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
`else
    pe_issue_arbiter_if #(.N_REQ(N_REQ)) bus ();
    pe_issue_arbiter #(.N_REQ(N_REQ), .PE_LAT(PE_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
`endif

    function automatic logic [31:0] pe_func(input logic [31:0] opc, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] c);
        case (opc)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return a * b;
            default: return a ^ b ^ c;
        endcase
    endfunction

    // PE model: fixed latency, with hooks to inject an orphan result or swallow one.
    logic              inject;
    logic              drop;
    logic [31:0]       inject_data;
    logic [PE_LAT-1:0] pipe_vld;
    logic [31:0]       pipe_data [PE_LAT];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0]  <= bus.pe_valid && !drop;
            pipe_data[0] <= pe_func(bus.pe_opcode, bus.pe_op1, bus.pe_op2, bus.pe_op3);
            for (int s = 1; s < int'(PE_LAT); s++) begin
                pipe_vld[s]  <= pipe_vld[s-1];
                pipe_data[s] <= pipe_data[s-1];
            end
        end
    end

    assign bus.pe_result_valid = pipe_vld[PE_LAT-1] | inject;
    assign bus.pe_result       = inject ? inject_data : pipe_data[PE_LAT-1];

    task automatic set_req(input int i, input logic [31:0] opc, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] c);
        bus.req_opcode[32*i +: 32] = opc;
        bus.req_op1[32*i +: 32]    = a;
        bus.req_op2[32*i +: 32]    = b;
        bus.req_op3[32*i +: 32]    = c;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.hold      = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        bus.req_valid = '1;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++;
            $display("FAIL reset_ready: got %b expected 0000", bus.req_ready); end
        checks++; if (bus.pe_valid !== 1'b0) begin errors++;
            $display("FAIL reset_pe_valid: got %b expected 0", bus.pe_valid); end
        checks++; if (bus.pe_opcode !== 32'h0 || bus.pe_op1 !== 32'h0) begin errors++;
            $display("FAIL reset_pe_ops: got %h/%h expected 0", bus.pe_opcode, bus.pe_op1); end
        checks++; if (bus.rsp_valid !== 4'b0000 || bus.rsp_data !== 32'h0) begin errors++;
            $display("FAIL reset_rsp: got %b/%h expected 0/0", bus.rsp_valid, bus.rsp_data); end
        checks++; if (bus.idle !== 1'b1 || bus.err_sync !== 1'b0) begin errors++;
            $display("FAIL reset_status: idle %b err %b expected 1/0", bus.idle, bus.err_sync); end
        @(negedge clk);
        bus.req_valid = '0;
        rst_n         = 1'b1;
    endtask

    task automatic test_single_issue();
        @(negedge clk);
        set_req(2, OP_ADD, 32'd10, 32'd20, 32'd0);
        bus.req_valid = 4'b0100;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++;
            $display("FAIL single_ready: got %b expected 0100", bus.req_ready); end
        for (int t = 1; t <= 5; t++) begin
            @(negedge clk);
            bus.req_valid = '0;
            #1;
            checks++; if (bus.pe_valid !== (t == 1)) begin errors++;
                $display("FAIL single_pe_valid t=%0d: got %b expected %b", t, bus.pe_valid, t == 1); end
            if (t == 1) begin
                checks++; if (bus.pe_opcode !== OP_ADD || bus.pe_op1 !== 32'd10 ||
                              bus.pe_op2 !== 32'd20) begin errors++;
                    $display("FAIL single_pe_ops: got %h %0d %0d expected %h 10 20",
                             bus.pe_opcode, bus.pe_op1, bus.pe_op2, OP_ADD); end
            end
            if (t == 4) begin
                checks++; if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== 32'd30) begin errors++;
                    $display("FAIL single_rsp: got %b/%0d expected 0100/30", bus.rsp_valid,
                             bus.rsp_data); end
            end else begin
                checks++; if (bus.rsp_valid !== 4'b0000) begin errors++;
                    $display("FAIL single_rsp_quiet t=%0d: got %b expected 0000", t, bus.rsp_valid); end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [N_REQ-1:0] exp_oh;
        logic [31:0]      exp_data;
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < int'(N_REQ); i++) set_req(i, OP_ADD, 32'(i + 1), 32'd100, 32'd0);
        bus.req_valid = '1;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++;
            $display("FAIL rr_ready_in_reset: got %b expected 0000", bus.req_ready); end
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            rst_n         = 1'b1;
            bus.req_valid = (t < 6) ? 4'b1111 : 4'b0000;
            #1;
            if (t < 6) begin
                exp_oh = '0; exp_oh[t % 4] = 1'b1;
                checks++; if (bus.req_ready !== exp_oh) begin errors++;
                    $display("FAIL rr_grant t=%0d: got %b expected %b", t, bus.req_ready, exp_oh); end
            end
            if (t >= 4 && t < 10) begin
                exp_oh = '0; exp_oh[(t - 4) % 4] = 1'b1;
                exp_data = 32'((t - 4) % 4 + 101);
                checks++; if (bus.rsp_valid !== exp_oh || bus.rsp_data !== exp_data) begin errors++;
                    $display("FAIL rr_rsp t=%0d: got %b/%0d expected %b/%0d", t, bus.rsp_valid,
                             bus.rsp_data, exp_oh, exp_data); end
            end else begin
                checks++; if (bus.rsp_valid !== 4'b0000) begin errors++;
                    $display("FAIL rr_rsp_quiet t=%0d: got %b expected 0000", t, bus.rsp_valid); end
            end
        end
    endtask

    task automatic test_hold_drain();
        set_req(0, OP_ADD, 32'd1, 32'd2, 32'd0);
        set_req(1, OP_SUB, 32'd9, 32'd4, 32'd0);
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            bus.req_valid = (t == 0) ? 4'b0011 : (t == 1) ? 4'b0010 : 4'b1111;
            bus.hold      = (t >= 2);
            #1;
            if (t >= 2) begin
                checks++; if (bus.req_ready !== 4'b0000) begin errors++;
                    $display("FAIL hold_ready t=%0d: got %b expected 0000", t, bus.req_ready); end
            end
            if (t == 3) begin
                checks++; if (bus.idle !== 1'b0) begin errors++;
                    $display("FAIL hold_busy: idle got %b expected 0", bus.idle); end
            end
            if (t == 4) begin
                checks++; if (bus.rsp_valid !== 4'b0001 || bus.rsp_data !== 32'd3) begin errors++;
                    $display("FAIL hold_rsp0: got %b/%0d expected 0001/3", bus.rsp_valid,
                             bus.rsp_data); end
            end
            if (t == 5) begin
                checks++; if (bus.rsp_valid !== 4'b0010 || bus.rsp_data !== 32'd5) begin errors++;
                    $display("FAIL hold_rsp1: got %b/%0d expected 0010/5", bus.rsp_valid,
                             bus.rsp_data); end
            end
            if (t == 7) begin
                checks++; if (bus.idle !== 1'b1 || bus.rsp_valid !== 4'b0000) begin errors++;
                    $display("FAIL hold_idle: idle %b rsp %b expected 1/0000", bus.idle,
                             bus.rsp_valid); end
            end
        end
        @(negedge clk);
        bus.req_valid = '0;
        bus.hold      = 1'b0;
    endtask

    task automatic test_mixed();
        set_req(1, OP_MUL, 32'd10, 32'd5, 32'd0);
        set_req(3, OP_SUB, 32'd50, 32'd20, 32'd0);
        for (int t = 0; t < 7; t++) begin
            @(negedge clk);
            bus.req_valid = (t == 0) ? 4'b0010 : (t == 1) ? 4'b1000 : 4'b0000;
            #1;
            if (t == 0 || t == 1) begin
                checks++; if (bus.req_ready !== bus.req_valid) begin errors++;
                    $display("FAIL mixed_ready t=%0d: got %b expected %b", t, bus.req_ready,
                             bus.req_valid); end
            end
            if (t == 4) begin
                checks++; if (bus.rsp_valid !== 4'b0010 || bus.rsp_data !== 32'd50) begin errors++;
                    $display("FAIL mixed_mul: got %b/%0d expected 0010/50", bus.rsp_valid,
                             bus.rsp_data); end
            end
            if (t == 5) begin
                checks++; if (bus.rsp_valid !== 4'b1000 || bus.rsp_data !== 32'd30) begin errors++;
                    $display("FAIL mixed_sub: got %b/%0d expected 1000/30", bus.rsp_valid,
                             bus.rsp_data); end
            end
        end
    endtask

    task automatic test_error();
        @(negedge clk);
        #1;
        checks++; if (bus.err_sync !== 1'b0) begin errors++;
            $display("FAIL err_clean: got %b expected 0", bus.err_sync); end
        inject      = 1'b1;
        inject_data = 32'hDEAD_BEEF;
        @(negedge clk);
        inject = 1'b0;
        for (int t = 0; t < 4; t++) begin
            #1;
            checks++; if (bus.rsp_valid !== 4'b0000 || bus.err_sync !== 1'b1) begin errors++;
                $display("FAIL err_orphan t=%0d: rsp %b err %b expected 0000/1", t, bus.rsp_valid,
                         bus.err_sync); end
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.err_sync !== 1'b0) begin errors++;
            $display("FAIL err_reset: got %b expected 0", bus.err_sync); end
        @(negedge clk);
        rst_n = 1'b1;
        // A granted op whose result never arrives must also flag.
        drop = 1'b1;
        set_req(0, OP_ADD, 32'd7, 32'd8, 32'd0);
        @(negedge clk);
        bus.req_valid = 4'b0001;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            bus.req_valid = '0;
            #1;
            checks++; if (bus.rsp_valid !== 4'b0000) begin errors++;
                $display("FAIL err_missing_rsp t=%0d: got %b expected 0000", t, bus.rsp_valid); end
        end
        checks++; if (bus.err_sync !== 1'b1) begin errors++;
            $display("FAIL err_missing: got %b expected 1", bus.err_sync); end
        drop = 1'b0;
    endtask

    task automatic test_random();
        rsp_t             exp_q[$];
        rsp_t             r;
        logic [N_REQ-1:0] pend;
        logic [N_REQ-1:0] exp_ready;
        logic [N_REQ-1:0] exp_oh;
        logic [31:0]      p_opc [N_REQ];
        logic [31:0]      p_a   [N_REQ];
        logic [31:0]      p_b   [N_REQ];
        logic [31:0]      p_c   [N_REQ];
        logic [31:0]      opcodes [4];
        logic             exp_pe;
        logic [31:0]      exp_opc;
        logic [31:0]      exp_a;
        logic [31:0]      exp_c;
        int               rr;
        int               win;
        opcodes = '{OP_ADD, OP_SUB, OP_MUL, OP_XOR};
        pulse_reset();
        pend   = '0;
        rr     = 0;
        exp_pe = 1'b0;
        exp_opc = '0; exp_a = '0; exp_c = '0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (t < 380) begin
                for (int i = 0; i < int'(N_REQ); i++) begin
                    if (!pend[i] && $urandom_range(0, 2) == 0) begin
                        p_opc[i] = opcodes[$urandom_range(0, 3)];
                        p_a[i] = $urandom; p_b[i] = $urandom; p_c[i] = $urandom;
                        set_req(i, p_opc[i], p_a[i], p_b[i], p_c[i]);
                        pend[i] = 1'b1;
                    end
                end
            end
            bus.hold      = (t < 380) && ($urandom_range(0, 7) == 0);
            bus.req_valid = pend;
            #1;
            win = -1;
            if (!bus.hold) begin
                for (int k = 0; k < int'(N_REQ); k++) begin
                    if (win < 0 && pend[(rr + k) % N_REQ]) win = (rr + k) % N_REQ;
                end
            end
            exp_ready = '0;
            if (win >= 0) exp_ready[win] = 1'b1;
            checks++; if (bus.req_ready !== exp_ready) begin errors++;
                $display("FAIL rand_ready t=%0d: got %b expected %b", t, bus.req_ready, exp_ready); end
            checks++; if (bus.pe_valid !== exp_pe) begin errors++;
                $display("FAIL rand_pe_valid t=%0d: got %b expected %b", t, bus.pe_valid, exp_pe); end
            if (exp_pe) begin
                checks++; if (bus.pe_opcode !== exp_opc || bus.pe_op1 !== exp_a ||
                              bus.pe_op3 !== exp_c) begin errors++;
                    $display("FAIL rand_pe_ops t=%0d: got %h %h %h expected %h %h %h", t,
                             bus.pe_opcode, bus.pe_op1, bus.pe_op3, exp_opc, exp_a, exp_c); end
            end
            if (exp_q.size() > 0 && exp_q[0].due == t) begin
                r = exp_q.pop_front();
                exp_oh = '0; exp_oh[r.id] = 1'b1;
                checks++; if (bus.rsp_valid !== exp_oh || bus.rsp_data !== r.data) begin errors++;
                    $display("FAIL rand_rsp t=%0d: got %b/%h expected %b/%h", t, bus.rsp_valid,
                             bus.rsp_data, exp_oh, r.data); end
            end else begin
                checks++; if (bus.rsp_valid !== 4'b0000) begin errors++;
                    $display("FAIL rand_rsp_quiet t=%0d: got %b expected 0000", t, bus.rsp_valid); end
            end
            exp_pe = 1'b0;
            if (win >= 0) begin
                exp_pe  = 1'b1;
                exp_opc = p_opc[win]; exp_a = p_a[win]; exp_c = p_c[win];
                r.due  = t + int'(PE_LAT) + 2;
                r.id   = win;
                r.data = pe_func(p_opc[win], p_a[win], p_b[win], p_c[win]);
                exp_q.push_back(r);
                pend[win] = 1'b0;
                rr = (win + 1) % N_REQ;
            end
        end
        checks++; if (exp_q.size() != 0 || bus.err_sync !== 1'b0) begin errors++;
            $display("FAIL rand_drain: %0d responses outstanding, err %b expected 0/0",
                     exp_q.size(), bus.err_sync); end
        @(negedge clk);
        bus.req_valid = '0;
        bus.hold      = 1'b0;
    endtask

`ifdef PE_ARB_STATS_EN
    task automatic test_stats();
        logic [CNT_W*N_REQ-1:0] cnt;
        pulse_reset();
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            bus.req_valid = (t < 5) ? 4'b0001 : 4'b0010;
        end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        cnt = bus.grant_cnt;
        checks++; if (cnt[0 +: CNT_W] !== 3'd5 || cnt[CNT_W +: CNT_W] !== 3'd3 ||
                      cnt[2*CNT_W +: 2*CNT_W] !== '0) begin errors++;
            $display("FAIL stats_count: got %h expected slices 5,3,0,0", cnt); end
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            bus.req_valid = 4'b0001;
        end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        cnt = bus.grant_cnt;
        checks++; if (cnt[0 +: CNT_W] !== 3'd7 || cnt[CNT_W +: CNT_W] !== 3'd3) begin errors++;
            $display("FAIL stats_saturate: got %h expected slices 7,3", cnt); end
    endtask
`endif

    initial begin
        bus.req_valid  = '0;
        bus.req_opcode = '0;
        bus.req_op1    = '0;
        bus.req_op2    = '0;
        bus.req_op3    = '0;
        bus.hold       = 1'b0;
        inject         = 1'b0;
        inject_data    = '0;
        drop           = 1'b0;
        rst_n          = 1'b1;
        #2 rst_n       = 1'b0;
        test_reset();
        test_single_issue();
        test_round_robin();
        test_hold_drain();
        test_mixed();
        test_error();
        test_random();
`ifdef PE_ARB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
